// File: rtl/parking_arith_pkg.sv
// Shared arithmetic definitions for the parking fee/occupancy datapaths:
// divider state encoding, default operand width and counter sizing.
package parking_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // Iteration counter width; counts WIDTH-1 down to 0.
    function automatic int cnt_width(input int w);
        if (w > 1) begin
            return $clog2(w);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/trial_subtractor.sv
// Ripple subtractor used for the divider's trial step, assembled from the
// shared full-adder cell in subtract mode (b inverted, carry-in high).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module trial_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic         sub_sel_s;
    logic [N-1:0] b_eff_s;
    logic [N:0]   carry_s;

    assign sub_sel_s  = 1'b1;
    assign b_eff_s    = b ^ {N{sub_sel_s}};
    assign carry_s[0] = sub_sel_s;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b_eff_s[i]),
            .ci (carry_s[i]),
            .s  (diff[i]),
            .co (carry_s[i+1])
        );
    end

    // A missing carry-out in two's-complement subtraction means a < b.
    assign borrow = ~carry_s[N];

endmodule

// File: rtl/fee_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done
// handshake, registered results with divide-by-zero flag.
module fee_divider
    import parking_arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    div_state_e       state_r, state_nx;
    logic [WIDTH:0]   acc_r, acc_nx;
    logic [WIDTH-1:0] q_r, q_nx;
    logic [WIDTH-1:0] div_r, div_nx;
    logic [CW-1:0]    cnt_r, cnt_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;
    logic [WIDTH-1:0] quot_r, quot_nx;
    logic [WIDTH-1:0] rem_r, rem_nx;
    logic             dbz_r, dbz_nx;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             borrow_s;

    // Accumulator MSB is always zero between steps since acc < divisor.
    assign shifted_s = (acc_r << 1'b1) | {{WIDTH{1'b0}}, q_r[WIDTH-1]};

    trial_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a      (shifted_s),
        .b      ({1'b0, div_r}),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_nx = state_r;
        acc_nx   = acc_r;
        q_nx     = q_r;
        div_nx   = div_r;
        cnt_nx   = cnt_r;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        quot_nx  = quot_r;
        rem_nx   = rem_r;
        dbz_nx   = dbz_r;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    div_nx = divisor;
                    acc_nx = {(WIDTH+1){1'b0}};
                    q_nx   = dividend;
                    cnt_nx = CNT_LOAD;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        quot_nx  = {WIDTH{1'b1}};
                        rem_nx   = dividend;
                        dbz_nx   = 1'b1;
                    end else begin
                        state_nx = CALC;
                        busy_nx  = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                if (borrow_s) begin
                    acc_nx = shifted_s;
                end else begin
                    acc_nx = diff_s;
                end
                q_nx   = {q_r[WIDTH-2:0], ~borrow_s};
                cnt_nx = cnt_r - CNT_ONE;
                if (cnt_r == {CW{1'b0}}) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    quot_nx  = q_nx;
                    rem_nx   = acc_nx[WIDTH-1:0];
                    dbz_nx   = 1'b0;
                end else begin
                    busy_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {(WIDTH+1){1'b0}};
            q_r    <= {WIDTH{1'b0}};
            div_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            quot_r <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            dbz_r  <= 1'b0;
        end else begin
            acc_r  <= acc_nx;
            q_r    <= q_nx;
            div_r  <= div_nx;
            cnt_r  <= cnt_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
            quot_r <= quot_nx;
            rem_r  <= rem_nx;
            dbz_r  <= dbz_nx;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quot_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_fee_divider.sv
// Scoreboard bench for fee_divider: directed cases plus randomized
// back-to-back divisions checked against plain integer division.
module tb_fee_divider;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int q;
        int r;
        int dbz;
        int sc;
        int lat;
    } exp_t;

    exp_t sb[$];

    fee_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(quotient), e.q);
                chk("remainder", int'(remainder), e.r);
                chk("div_by_zero", int'(div_by_zero), e.dbz);
                chk("latency", cyc - e.sc, e.lat);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Issue one division at the current negedge and wait for its done cycle.
    // inj >= 0 pulses a foreign start (10/3) that many cycles into the run.
    task automatic run_op(input int a, input int d, input int inj);
        exp_t e;
        int   busy_cnt;
        bit   got;
        if (d == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.dbz = 1;
            e.lat = 0;
        end else begin
            e.q = a / d;
            e.r = a % d;
            e.dbz = 0;
            e.lat = W;
        end
        e.sc = cyc + 1;
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(d);
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (k == inj) begin
                start    = 1'b1;
                dividend = 8'd10;
                divisor  = 8'd3;
            end else begin
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", int'(got), 1);
        chk("busy_cycles", busy_cnt, e.lat);
    endtask

    initial begin
        int a;
        int d;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(100, 7, -1);
        run_op(255, 1, -1);
        run_op(255, 255, -1);
        run_op(5, 9, -1);
        run_op(42, 0, -1);
        repeat (2) @(negedge clk);

        // Foreign start during CALC is ignored; then back-to-back from DONE.
        run_op(100, 7, 3);
        run_op(200, 60, -1);
        repeat (2) @(negedge clk);

        // Asynchronous abort mid-operation: nothing is pushed for it.
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(60, 60, -1);
        run_op(0, 5, -1);
        run_op(0, 0, -1);
        run_op(1, 2, -1);

        // Randomized back-to-back sweep, divisor zero about 1 in 16.
        for (int i = 0; i < 3000; i++) begin
            a = int'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                d = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                d = int'($urandom_range(1, 15));
            end else begin
                d = int'($urandom_range(1, 255));
            end
            run_op(a, d, -1);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
